lc4_div_sched: RTL and testbench
================================

Name: lc4_div_sched

Overview:
- Multi-cycle scheduler for the LC4 unsigned divide/modulo resource.
- Two requesters share one iterative restoring-division datapath, for example the ALU DIV/MOD path and a second pipeline or test port.
- The block arbitrates round-robin, latches operands, runs one quotient bit per cycle, and holds the result until the owner acknowledges it.
- LC4 semantics: divisor 0 gives quotient 0 and remainder 0.

Parameters:
- WIDTH, 16, operand/result width; iteration count equals WIDTH.
- ZERO_FAST, 1, when 1 a zero divisor skips iteration and completes on the cycle after acceptance; when 0 it runs the full WIDTH iterations and still returns 0/0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_req0  input  1  requester 0 wants a divide; held high until granted.
- i_dividend0  input  WIDTH  requester 0 dividend, valid while i_req0.
- i_divisor0  input  WIDTH  requester 0 divisor, valid while i_req0.
- o_gnt0  output  1  combinational; high in the accept cycle for requester 0.
- i_req1  input  1  requester 1 request.
- i_dividend1  input  WIDTH  requester 1 dividend.
- i_divisor1  input  WIDTH  requester 1 divisor.
- o_gnt1  output  1  combinational; accept for requester 1.
- o_busy  output  1  high whenever state is not IDLE.
- o_valid  output  1  result available (DONE state).
- o_owner  output  1  index of the requester the current or last result belongs to.
- o_quotient  output  WIDTH  unsigned quotient.
- o_remainder  output  WIDTH  unsigned remainder.
- i_ack  input  1  owner consumes the result; sampled only while o_valid.

Behaviour:
- Reset (rst high at a clk edge) does all of the following:
  - state goes to IDLE;
  - o_busy, o_valid, o_owner, o_quotient and o_remainder all become 0;
  - step counter is cleared;
  - the round-robin pointer favours requester 0.
- Reset mid-RUN or mid-DONE abandons the operation; no o_valid is produced for it.
- States: IDLE, RUN, DONE.
- IDLE, arbitration:
  - If exactly one request is high, that requester is granted.
  - If both are high, grant the requester not served last (pointer); after reset, grant 0.
- IDLE, accept:
  - o_gnt for the winner is high combinationally in the same cycle; at most one gnt is high.
  - gnt is never asserted outside IDLE or during rst.
- At the accept edge:
  - latch dividend, divisor and owner;
  - clear the partial remainder and load the quotient shift register with the dividend;
  - counter = WIDTH-1;
  - state -> RUN, or -> DONE with q=0, r=0 if the divisor is 0 and ZERO_FAST=1.
- RUN step, one per cycle:
  - r' = {r[WIDTH-2:0], q[WIDTH-1]};
  - if r' >= divisor (unsigned), r = r' - divisor and shift 1 into q; else r = r' and shift 0 into q.
  - The compare/subtract uses WIDTH+1 bits so that no carry is lost.
- RUN exit: on the step where counter == 0, state -> DONE. Counter decrements otherwise.
- Latency: accept at edge E0; steps at E1..E16 (WIDTH=16); o_valid is high in the cycle after E16. Accept-to-valid is 17 cycles.
- Zero divisor with ZERO_FAST=1: o_valid is high in the cycle after E0. Zero divisor with ZERO_FAST=0: the 16 iterations run and the result is forced to 0/0 at DONE entry.
- DONE:
  - o_valid = 1; o_quotient, o_remainder and o_owner are stable and held indefinitely until i_ack.
  - At the edge where i_ack is high, state -> IDLE, o_valid -> 0, and the pointer records the owner.
  - The quotient and remainder values persist after ack until the next DONE entry.
  - A new request cannot be accepted on the ack edge; at least one IDLE cycle separates operations.
- Requests arriving during RUN/DONE are ignored (no gnt). Requesters keep req high and are served in a later IDLE cycle.
- i_ack outside DONE has no effect.

Test Plan:
- Single request, requester 0, 100 / 7 -> o_gnt0 for 1 cycle; o_valid exactly 17 cycles after accept; q=14, r=2, owner=0. Result held for 5 cycles while i_ack is low.
- Boundaries:
  - 0xFFFF / 1 -> q=0xFFFF, r=0.
  - 5 / 0xFFFF -> q=0, r=5.
  - 0x8000 / 0x8000 -> q=1, r=0.
- Divide by zero, ZERO_FAST=1, 1234 / 0 -> o_valid the cycle after accept, q=0, r=0. Repeat with ZERO_FAST=0 -> valid after 17 cycles, still 0/0.
- Both requests held continuously from reset:
  - grants alternate 0, 1, 0, 1;
  - each accept is at least 1 cycle after the previous ack;
  - never two gnts in one cycle;
  - o_owner matches each grant.
- rst asserted for 1 cycle at step 8 of a RUN -> next cycle o_busy=0, o_valid=0, outputs 0. A new request afterwards completes correctly with the pointer favouring requester 0.
- i_ack pulsed in IDLE and RUN -> no state change. i_req1 raised mid-RUN -> no o_gnt1 until IDLE.

Source files
------------

// File: rtl/lc4_div_sched.sv
// LC4 unsigned divide/modulo scheduler: two requesters share one restoring divider
// through round-robin arbitration. The result is held until the owner acknowledges it.
module lc4_div_sched #(
   parameter int WIDTH     = 16,
   parameter int ZERO_FAST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req0,
   input  logic [WIDTH-1:0] i_dividend0,
   input  logic [WIDTH-1:0] i_divisor0,
   output logic             o_gnt0,
   input  logic             i_req1,
   input  logic [WIDTH-1:0] i_dividend1,
   input  logic [WIDTH-1:0] i_divisor1,
   output logic             o_gnt1,
   output logic             o_busy,
   output logic             o_valid,
   output logic             o_owner,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   input  logic             i_ack
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(0);
   localparam logic FAST_EN = (ZERO_FAST != 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic             last_r;
   logic             owner_r;
   logic [WIDTH-1:0] divisor_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] quot_r;
   logic [WIDTH-1:0] rem_r;
   logic [CW-1:0]    cnt_r;

   logic             gnt0_s;
   logic             gnt1_s;
   logic             accept_s;
   logic [WIDTH-1:0] sel_dividend_s;
   logic [WIDTH-1:0] sel_divisor_s;
   logic             fast_zero_s;
   logic             last_step_s;
   logic             div_zero_s;
   logic [WIDTH:0]   shifted_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH-1:0] step_q_s;
   logic [WIDTH-1:0] step_r_s;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Round-robin grant: only in IDLE and never while reset is asserted
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if ((state_r == ST_IDLE) && !rst) begin
         if (i_req0 && i_req1) begin
            if (last_r) begin
               gnt0_s = 1'b1;
            end else begin
               gnt1_s = 1'b1;
            end
         end else if (i_req0) begin
            gnt0_s = 1'b1;
         end else if (i_req1) begin
            gnt1_s = 1'b1;
         end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Operand selection for the winning requester
   always_comb begin
      accept_s = gnt0_s | gnt1_s;
      if (gnt1_s) begin
         sel_dividend_s = i_dividend1;
         sel_divisor_s  = i_divisor1;
      end else begin
         sel_dividend_s = i_dividend0;
         sel_divisor_s  = i_divisor0;
      end
      fast_zero_s = FAST_EN && (sel_divisor_s == ZERO_W);
      last_step_s = (cnt_r == CNT_ZERO);
      div_zero_s  = (divisor_r == ZERO_W);
   end

   // One restoring-division step; the extra bit keeps the shifted-out remainder MSB
   always_comb begin
      shifted_s = {r_r, q_r[WIDTH-1]};
      diff_s    = shifted_s - {1'b0, divisor_r};
      if (!diff_s[WIDTH]) begin
         step_r_s = diff_s[WIDTH-1:0];
         step_q_s = {q_r[WIDTH-2:0], 1'b1};
      end else begin
         step_r_s = shifted_s[WIDTH-1:0];
         step_q_s = {q_r[WIDTH-2:0], 1'b0};
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (fast_zero_s) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_step_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (i_ack) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Operand latch, iteration datapath, held result and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         last_r    <= 1'b1;
         owner_r   <= 1'b0;
         divisor_r <= ZERO_W;
         q_r       <= ZERO_W;
         r_r       <= ZERO_W;
         quot_r    <= ZERO_W;
         rem_r     <= ZERO_W;
         cnt_r     <= CNT_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  owner_r   <= gnt1_s;
                  divisor_r <= sel_divisor_s;
                  q_r       <= sel_dividend_s;
                  r_r       <= ZERO_W;
                  cnt_r     <= CNT_LAST;
                  if (fast_zero_s) begin
                     quot_r <= ZERO_W;
                     rem_r  <= ZERO_W;
                  end
               end
            end
            ST_RUN: begin
               q_r <= step_q_s;
               r_r <= step_r_s;
               if (last_step_s) begin
                  // LC4 defines x/0 and x%0 as zero
                  quot_r <= div_zero_s ? ZERO_W : step_q_s;
                  rem_r  <= div_zero_s ? ZERO_W : step_r_s;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_DONE: begin
               if (i_ack) begin
                  last_r <= owner_r;
               end
            end
            default: begin
               last_r <= last_r;
            end
         endcase
      end
   end

   assign o_gnt0      = gnt0_s;
   assign o_gnt1      = gnt1_s;
   assign o_busy      = (state_r != ST_IDLE);
   assign o_valid     = (state_r == ST_DONE);
   assign o_owner     = owner_r;
   assign o_quotient  = quot_r;
   assign o_remainder = rem_r;

endmodule

// File: tb/tb_lc4_div_sched.sv
// Scoreboard bench for lc4_div_sched: a ZERO_FAST=1 instance carries most scenarios,
// and a ZERO_FAST=0 instance covers the slow divide-by-zero path.
`timescale 1ns/1ps
module tb_lc4_div_sched;

   typedef struct packed {
      logic        owner;
      logic [15:0] q;
      logic [15:0] r;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, ack = 1'b0;
   logic [15:0] dd0 = 16'd0, ds0 = 16'd0, dd1 = 16'd0, ds1 = 16'd0;
   logic        gnt0, gnt1, busy, valid, owner;
   logic [15:0] quo, rem;

   logic        s_req0 = 1'b0, s_ack = 1'b0;
   logic [15:0] s_dd0 = 16'd0, s_ds0 = 16'd0;
   logic        s_gnt0, s_gnt1, s_busy, s_valid, s_owner;
   logic [15:0] s_quo, s_rem;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   lc4_div_sched #(.WIDTH(16), .ZERO_FAST(1)) u_dut (
      .clk(clk), .rst(rst),
      .i_req0(req0), .i_dividend0(dd0), .i_divisor0(ds0), .o_gnt0(gnt0),
      .i_req1(req1), .i_dividend1(dd1), .i_divisor1(ds1), .o_gnt1(gnt1),
      .o_busy(busy), .o_valid(valid), .o_owner(owner),
      .o_quotient(quo), .o_remainder(rem), .i_ack(ack)
   );

   lc4_div_sched #(.WIDTH(16), .ZERO_FAST(0)) u_dut_slow (
      .clk(clk), .rst(rst),
      .i_req0(s_req0), .i_dividend0(s_dd0), .i_divisor0(s_ds0), .o_gnt0(s_gnt0),
      .i_req1(1'b0), .i_dividend1(16'd0), .i_divisor1(16'd0), .o_gnt1(s_gnt1),
      .o_busy(s_busy), .o_valid(s_valid), .o_owner(s_owner),
      .o_quotient(s_quo), .o_remainder(s_rem), .i_ack(s_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic who, input logic [15:0] dd, input logic [15:0] ds);
      exp_t e;
      e.owner = who;
      e.q = (ds == 16'd0) ? 16'd0 : dd / ds;
      e.r = (ds == 16'd0) ? 16'd0 : dd % ds;
      return e;
   endfunction

   task automatic compare_result(input string name);
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (owner !== e.owner || quo !== e.q || rem !== e.r)
         $display("FAIL %s: got owner=%0d q=%h r=%h, expected owner=%0d q=%h r=%h",
                  name, owner, quo, rem, e.owner, e.q, e.r);
      if (owner !== e.owner || quo !== e.q || rem !== e.r) errors++;
   endtask

   task automatic run_op(input logic who, input logic [15:0] dd, input logic [15:0] ds,
                         input int exp_lat, input int hold, input string name);
      int t;
      int n;
      exp_t e;
      @(negedge clk);
      if (who) begin req1 = 1'b1; dd1 = dd; ds1 = ds; end
      else begin req0 = 1'b1; dd0 = dd; ds0 = ds; end
      #1;
      t = 0;
      while (((who ? gnt1 : gnt0) !== 1'b1) && t < 100) begin
         @(negedge clk); #1; t++;
      end
      checks++;
      if (t >= 100) begin
         errors++; $display("FAIL %s_grant: no grant for requester %0d", name, who);
         req0 = 1'b0; req1 = 1'b0; return;
      end
      checks++;
      if ((who ? gnt0 : gnt1) !== 1'b0) begin
         errors++; $display("FAIL %s_gnt_excl: both grants high", name);
      end
      sb.push_back(model(who, dd, ds));
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      n = 1;
      while (valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (n != exp_lat) begin
         errors++; $display("FAIL %s_latency: got %0d cycles, expected %0d", name, n, exp_lat);
      end
      e = sb[0];
      compare_result(name);
      repeat (hold) begin
         @(negedge clk);
         checks++;
         if (valid !== 1'b1 || quo !== e.q || rem !== e.r || owner !== e.owner) begin
            errors++;
            $display("FAIL %s_hold: valid=%0d q=%h r=%h, expected valid=1 q=%h r=%h",
                     name, valid, quo, rem, e.q, e.r);
         end
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || quo !== e.q || rem !== e.r) begin
         errors++;
         $display("FAIL %s_after_ack: valid=%0d busy=%0d q=%h r=%h, expected 0 0 %h %h",
                  name, valid, busy, quo, rem, e.q, e.r);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; req0 = 1'b1; dd0 = 16'd9; ds0 = 16'd3;
      @(negedge clk); #1;
      checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
         errors++; $display("FAIL reset_gnt: gnt0=%0d gnt1=%0d, expected 0 0", gnt0, gnt1);
      end
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0 || owner !== 1'b0 || quo !== 16'd0 || rem !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%0d valid=%0d owner=%0d q=%h r=%h, expected all 0",
                  busy, valid, owner, quo, rem);
      end
      @(negedge clk);
      rst = 1'b0; req0 = 1'b0;
   endtask

   task automatic test_single();
      run_op(1'b0, 16'd100, 16'd7, 17, 5, "single_100_7");
   endtask

   task automatic test_boundaries();
      run_op(1'b1, 16'hFFFF, 16'h0001, 17, 0, "bnd_ffff_1");
      run_op(1'b0, 16'h0005, 16'hFFFF, 17, 0, "bnd_5_ffff");
      run_op(1'b1, 16'h8000, 16'h8000, 17, 0, "bnd_8000_8000");
      run_op(1'b0, 16'hFFFE, 16'hFFFF, 17, 0, "bnd_fffe_ffff");
      run_op(1'b0, 16'd1234, 16'd0, 1, 2, "zero_fast");
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [15:0] b;
      for (int k = 0; k < 6; k++) begin
         a = 16'($urandom);
         b = 16'($urandom_range(1, 65535)) >> $urandom_range(0, 12);
         run_op(k[0], a, b, (b == 16'd0) ? 1 : 17, 0, "random");
      end
   endtask

   task automatic test_zero_slow();
      int t;
      int n;
      @(negedge clk);
      s_req0 = 1'b1; s_dd0 = 16'd1234; s_ds0 = 16'd0;
      #1;
      t = 0;
      while (s_gnt0 !== 1'b1 && t < 100) begin @(negedge clk); #1; t++; end
      checks++;
      if (t >= 100) begin
         errors++; $display("FAIL zero_slow_grant: no grant");
         s_req0 = 1'b0; return;
      end
      @(negedge clk);
      s_req0 = 1'b0;
      n = 1;
      while (s_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (n != 17 || s_quo !== 16'd0 || s_rem !== 16'd0 || s_owner !== 1'b0) begin
         errors++;
         $display("FAIL zero_slow: latency=%0d q=%h r=%h owner=%0d, expected 17 0000 0000 0",
                  n, s_quo, s_rem, s_owner);
      end
      s_ack = 1'b1;
      @(negedge clk);
      s_ack = 1'b0;
      checks++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
         errors++; $display("FAIL zero_slow_ack: valid=%0d busy=%0d, expected 0 0", s_valid, s_busy);
      end
   endtask

   task automatic test_round_robin();
      int t;
      int ack_cyc;
      int n;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req0 = 1'b1; dd0 = 16'd1000; ds0 = 16'd9;
      req1 = 1'b1; dd1 = 16'd500;  ds1 = 16'd7;
      ack_cyc = -1;
      for (int k = 0; k < 4; k++) begin
         #1;
         t = 0;
         while (gnt0 !== 1'b1 && gnt1 !== 1'b1 && t < 100) begin @(negedge clk); #1; t++; end
         checks++;
         if (t >= 100) begin
            errors++; $display("FAIL rr_grant: no grant in round %0d", k);
            break;
         end
         checks++;
         if ((gnt0 & gnt1) !== 1'b0 || gnt1 !== k[0]) begin
            errors++;
            $display("FAIL rr_order: round %0d gnt0=%0d gnt1=%0d, expected gnt%0d only",
                     k, gnt0, gnt1, k[0]);
         end
         checks++;
         if (k > 0 && cyc <= ack_cyc) begin
            errors++; $display("FAIL rr_gap: accept at cycle %0d, ack at %0d", cyc, ack_cyc);
         end
         sb.push_back(gnt1 ? model(1'b1, dd1, ds1) : model(1'b0, dd0, ds0));
         @(negedge clk);
         n = 1;
         while (valid !== 1'b1 && n < 200) begin
            #1;
            checks++;
            if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
               errors++; $display("FAIL rr_gnt_busy: gnt0=%0d gnt1=%0d while busy", gnt0, gnt1);
            end
            @(negedge clk); n++;
         end
         compare_result("rr_result");
         ack = 1'b1;
         ack_cyc = cyc;
         @(negedge clk);
         ack = 1'b0;
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ack_and_late_req();
      int n;
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         errors++; $display("FAIL ack_idle: busy=%0d valid=%0d, expected 0 0", busy, valid);
      end
      req0 = 1'b1; dd0 = 16'd300; ds0 = 16'd17;
      #1;
      checks++;
      if (gnt0 !== 1'b1) begin
         errors++; $display("FAIL late_gnt0: gnt0=%0d, expected 1", gnt0);
      end
      sb.push_back(model(1'b0, 16'd300, 16'd17));
      @(negedge clk);
      req0 = 1'b0;
      n = 1;
      while (valid !== 1'b1 && n < 200) begin
         if (n == 3) ack = 1'b1;
         if (n == 4) ack = 1'b0;
         if (n == 5) begin req1 = 1'b1; dd1 = 16'd77; ds1 = 16'd5; end
         #1;
         checks++;
         if (busy !== 1'b1 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL run_ignore: step %0d busy=%0d gnt1=%0d, expected 1 0", n, busy, gnt1);
         end
         @(negedge clk); n++;
      end
      checks++;
      if (n != 17) begin
         errors++; $display("FAIL ack_run_latency: got %0d, expected 17", n);
      end
      compare_result("ack_run_result");
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      #1;
      checks++;
      if (gnt1 !== 1'b1) begin
         errors++; $display("FAIL late_gnt1: gnt1=%0d in first IDLE cycle, expected 1", gnt1);
      end
      sb.push_back(model(1'b1, 16'd77, 16'd5));
      @(negedge clk);
      req1 = 1'b0;
      n = 1;
      while (valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (n != 17) begin
         errors++; $display("FAIL late_req_latency: got %0d, expected 17", n);
      end
      compare_result("late_req_result");
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int n;
      // requester 0 served last, so an unreset pointer would favour requester 1
      run_op(1'b0, 16'd10, 16'd3, 17, 0, "pre_reset");
      @(negedge clk);
      req0 = 1'b1; dd0 = 16'd40000; ds0 = 16'd3;
      #1;
      checks++;
      if (gnt0 !== 1'b1) begin
         errors++; $display("FAIL mid_rst_gnt: gnt0=%0d, expected 1", gnt0);
      end
      sb.push_back(model(1'b0, 16'd40000, 16'd3));
      @(negedge clk);
      req0 = 1'b0;
      n = 1;
      while (n < 7) begin @(negedge clk); n++; end
      rst = 1'b1;
      req0 = 1'b1; dd0 = 16'd1000; ds0 = 16'd9;
      req1 = 1'b1; dd1 = 16'd500;  ds1 = 16'd7;
      #1;
      checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL mid_rst_during: gnt0=%0d gnt1=%0d busy=%0d, expected 0 0 1", gnt0, gnt1, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0 || owner !== 1'b0 || quo !== 16'd0 || rem !== 16'd0) begin
         errors++;
         $display("FAIL mid_rst_outputs: busy=%0d valid=%0d owner=%0d q=%h r=%h, expected all 0",
                  busy, valid, owner, quo, rem);
      end
      #1;
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         errors++; $display("FAIL mid_rst_pointer: gnt0=%0d gnt1=%0d, expected 1 0", gnt0, gnt1);
      end
      sb.push_back(model(1'b0, 16'd1000, 16'd9));
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      n = 1;
      while (valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (n != 17) begin
         errors++; $display("FAIL post_rst_latency: got %0d, expected 17", n);
      end
      compare_result("post_rst_result");
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_boundaries();
      test_zero_slow();
      test_random();
      test_round_robin();
      test_ack_and_late_req();
      test_reset_mid_run();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
